// File: rtl/ysyx_25040129_ifu.sv
// -----------------------------------------------------------------------------
// ysyx_25040129_ifu -- instruction fetch unit of the multicycle core.
//
// Holds the PC and issues one instruction-memory read per instruction. The
// fetched word goes to decode over a valid/ready handshake. After decode takes
// it, the unit waits for write-back to return the next PC and then fetches
// again. If the returned PC is misaligned, no bus request is made. The unit
// offers inst=0 with fetch_err=1 instead.
//
// Ports:
//   clk, rst                  clock (rising edge), async active-high reset
//   ifu_araddr/arvalid/arready  read address channel (araddr always == pc)
//   ifu_rdata/rresp/rvalid/rready read data channel (rresp != 0 is an error)
//   inst, pc, fetch_err       registered instruction, its address, error flag
//   is_req_valid_to_idu / is_req_ready_from_idu   handshake to decode
//   dnpc / is_req_valid_from_wbu / is_req_ready_to_wbu  next PC from write-back
//
// Optional feature (macro YSYX_25040129_IFU_PERF_EN):
//   perf_fetch_cnt  completed fetches (DATA->SEND), wraps mod 2^32
//   perf_stall_cnt  cycles spent in ADDR or DATA, wraps mod 2^32
//   plus a simulation-only message on every fetch error.
// -----------------------------------------------------------------------------
module ysyx_25040129_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] ifu_araddr,
  output logic        ifu_arvalid,
  input  logic        ifu_arready,
  input  logic [31:0] ifu_rdata,
  input  logic [1:0]  ifu_rresp,
  input  logic        ifu_rvalid,
  output logic        ifu_rready,
  output logic [31:0] inst,
  output logic [31:0] pc,
  output logic        fetch_err,
  output logic        is_req_valid_to_idu,
  input  logic        is_req_ready_from_idu,
  input  logic [31:0] dnpc,
  input  logic        is_req_valid_from_wbu,
  output logic        is_req_ready_to_wbu
`ifdef YSYX_25040129_IFU_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  typedef enum logic [2:0] {
    S_BOOT,
    S_ADDR,
    S_DATA,
    S_SEND,
    S_WAIT
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic        fetch_err_q, fetch_err_d;

  // NOTE: every signal assigned here gets its hold value first. Any path
  // through the case that skips a signal would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    inst_d      = inst_q;
    fetch_err_d = fetch_err_q;
    unique case (state_q)
      S_BOOT: state_d = S_ADDR;
      // ifu_arvalid is high throughout ADDR, so arready alone completes the handshake.
      S_ADDR: if (ifu_arready) state_d = S_DATA;
      S_DATA: begin
        if (ifu_rvalid) begin
          state_d     = S_SEND;
          inst_d      = ifu_rdata;
          fetch_err_d = (ifu_rresp != 2'b00);
        end
      end
      S_SEND: if (is_req_ready_from_idu) state_d = S_WAIT;
      S_WAIT: begin
        if (is_req_valid_from_wbu) begin
          pc_d = dnpc;
          if (dnpc[1:0] == 2'b00) begin
            state_d = S_ADDR;
          end else begin
            // A misaligned target is never put on the bus. It is reported to
            // decode directly as a faulting fetch.
            state_d     = S_SEND;
            inst_d      = 32'h0;
            fetch_err_d = 1'b1;
          end
        end
      end
      default: state_d = S_BOOT;
    endcase
  end

  // NOTE: state registers use non-blocking assignments. All flops then update
  // together at the edge, with no dependence on evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_BOOT;
      pc_q        <= RESET_PC;
      inst_q      <= 32'h0;
      fetch_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      inst_q      <= inst_d;
      fetch_err_q <= fetch_err_d;
    end
  end

  // Handshake outputs depend only on the state. Reset drops them at once.
  assign ifu_arvalid         = (state_q == S_ADDR);
  assign ifu_rready          = (state_q == S_DATA);
  assign is_req_valid_to_idu = (state_q == S_SEND);
  assign is_req_ready_to_wbu = (state_q == S_WAIT);

  assign ifu_araddr = pc_q;
  assign pc         = pc_q;
  assign inst       = inst_q;
  assign fetch_err  = fetch_err_q;

`ifdef YSYX_25040129_IFU_PERF_EN
  logic [31:0] perf_fetch_cnt_q, perf_fetch_cnt_d;
  logic [31:0] perf_stall_cnt_q, perf_stall_cnt_d;

  always_comb begin
    perf_fetch_cnt_d = perf_fetch_cnt_q;
    perf_stall_cnt_d = perf_stall_cnt_q;
    if ((state_q == S_DATA) && ifu_rvalid) perf_fetch_cnt_d = perf_fetch_cnt_q + 32'd1;
    if ((state_q == S_ADDR) || (state_q == S_DATA)) perf_stall_cnt_d = perf_stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_cnt_q <= 32'h0;
      perf_stall_cnt_q <= 32'h0;
    end else begin
      perf_fetch_cnt_q <= perf_fetch_cnt_d;
      perf_stall_cnt_q <= perf_stall_cnt_d;
    end
  end

  assign perf_fetch_cnt = perf_fetch_cnt_q;
  assign perf_stall_cnt = perf_stall_cnt_q;

`ifndef SYNTHESIS
  // Reports each faulting fetch once, as it enters SEND.
  always @(posedge clk) begin
    if (!rst && (state_d == S_SEND) && (state_q != S_SEND) && fetch_err_d)
      $display("ifu: fetch error at pc=%h", pc_d);
  end
`endif
`endif

endmodule
